// File: rtl/spi_pkg.sv
// Shared constants and FSM state encoding for the SPI initiator engine.
package spi_pkg;

  localparam int SPI_BUF_SIZE  = 9;
  localparam int SPI_CNT_WIDTH = $clog2(SPI_BUF_SIZE + 1);

  localparam logic SS_ACTIVE = 1'b1;
  localparam logic SCLK_IDLE = 1'b0;

  localparam int SPI_STATE_W = 3;

  typedef enum logic [SPI_STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_PH_LOW  = 3'd2,
    ST_PH_HIGH = 3'd3,
    ST_TAIL    = 3'd4,
    ST_HOLD    = 3'd5
  } spi_state_e;

endpackage

// File: rtl/sclk_divider.sv
// Half-period timer for the SPI initiator: phase_tick pulses on the last
// cycle of every CLK_DIV-cycle window while enable is held high.
module sclk_divider
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic enable,
  output logic phase_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q;

  // Held at zero while disabled so every phase starts a full window.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!enable || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign phase_tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/spi_master_engine.sv
// SPI initiator (SS active-high, SCLK idle low, sample on rise, shift on fall).
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first transmit/receive order.
module spi_master_engine
  import spi_pkg::*;
#(
  parameter  int BUF_SIZE = SPI_BUF_SIZE,
  parameter  int CLK_DIV  = 4,
  parameter  int SS_SETUP = 2,
  localparam int CNT_W    = $clog2(BUF_SIZE + 1)
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BUF_SIZE-1:0] data_in,
  input  logic [CNT_W-1:0]    write_count,
  input  logic                end_frame,
  input  logic                miso_in,
  output logic                sclk_out,
  output logic                ss_out,
  output logic                mosi_out,
  output logic [BUF_SIZE-1:0] data_out,
  output logic                done_sig,
  output logic                busy
);

  localparam int SET_W = $clog2(SS_SETUP + 1);

  spi_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, bit_idx_q, req_cnt;
  logic [SET_W-1:0]    setup_cnt_q;
  logic [BUF_SIZE-1:0] tx_q, rx_q, tx_load, tx_shift, rx_cap;
  logic                ef_q, accept, phase_tick, div_en, setup_last;
  logic                rise, fall_more, load_head, next_head, ss_d, sclk_d;

  assign req_cnt    = (write_count > CNT_W'(BUF_SIZE)) ? CNT_W'(BUF_SIZE) : write_count;
  assign accept     = start && (state_q == ST_IDLE || state_q == ST_HOLD);
  assign div_en     = state_q inside {ST_PH_LOW, ST_PH_HIGH, ST_TAIL};
  assign setup_last = (setup_cnt_q == SET_W'(SS_SETUP - 1));
  assign rise       = (state_d == ST_PH_HIGH) && (state_q != ST_PH_HIGH);
  assign fall_more  = (state_q == ST_PH_HIGH) && (state_d == ST_PH_LOW);
  assign data_out   = rx_q;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign tx_load   = data_in;
  assign tx_shift  = tx_q >> 1;
  assign load_head = tx_load[0];
  assign next_head = tx_shift[0];
`else
  // Left-align the active bits so the first one to send sits at the MSB.
  assign tx_load   = data_in << (BUF_SIZE - int'(req_cnt));
  assign tx_shift  = tx_q << 1;
  assign load_head = tx_load[BUF_SIZE-1];
  assign next_head = tx_shift[BUF_SIZE-1];
`endif

  always_comb begin
    rx_cap = rx_q;
`ifdef SPI_MASTER_LSB_FIRST_EN
    rx_cap[bit_idx_q] = miso_in;
`else
    rx_cap = {rx_q[BUF_SIZE-2:0], miso_in};
`endif
  end

  sclk_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .enable    (div_en),
    .phase_tick(phase_tick)
  );

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (start) begin
          if (req_cnt == '0)             state_d = end_frame ? ST_IDLE : ST_HOLD;
          else if (state_q == ST_IDLE)   state_d = ST_SETUP;
          else                           state_d = ST_PH_LOW;
        end
      end
      ST_SETUP:   if (setup_last) state_d = ST_PH_HIGH;
      ST_PH_HIGH: if (phase_tick) state_d = (bit_idx_q == cnt_q) ? ST_TAIL : ST_PH_LOW;
      ST_PH_LOW:  if (phase_tick) state_d = ST_PH_HIGH;
      ST_TAIL:    if (phase_tick) state_d = ef_q ? ST_IDLE : ST_HOLD;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Bus pins are decoded from the next state and registered, so they change
  // on the same edge as the state and never glitch.
  always_comb begin
    ss_d   = (state_d == ST_IDLE)    ? ~SS_ACTIVE : SS_ACTIVE;
    sclk_d = (state_d == ST_PH_HIGH) ? ~SCLK_IDLE : SCLK_IDLE;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      ss_out      <= ~SS_ACTIVE;
      sclk_out    <= SCLK_IDLE;
      mosi_out    <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      setup_cnt_q <= '0;
      ef_q        <= 1'b0;
      done_sig    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      ss_out      <= ss_d;
      sclk_out    <= sclk_d;
      setup_cnt_q <= (state_q == ST_SETUP) ? setup_cnt_q + 1'b1 : '0;
      if (accept) begin
        cnt_q     <= req_cnt;
        ef_q      <= end_frame;
        bit_idx_q <= '0;
        rx_q      <= '0;
        tx_q      <= tx_load;
        done_sig  <= (req_cnt == '0);
        busy      <= (req_cnt != '0);
        if (req_cnt != '0) mosi_out <= load_head;
      end
      if (rise) begin
        rx_q      <= rx_cap;
        bit_idx_q <= bit_idx_q + 1'b1;
      end
      if (fall_more) begin
        tx_q     <= tx_shift;
        mosi_out <= next_head;
      end
      if (state_q == ST_TAIL && phase_tick) begin
        done_sig <= 1'b1;
        busy     <= 1'b0;
      end
      if (state_d == ST_IDLE) mosi_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_master_engine.sv
// Bench for spi_master_engine: directed vector table, hold/glitch/reset
// sequences and randomized transfers against a bit-stream reference model.
module tb_spi_master_engine;

  localparam int BUF_SIZE = 9;
  localparam int CLK_DIV  = 2;
  localparam int SS_SETUP = 2;
  localparam int CNT_W    = $clog2(BUF_SIZE + 1);

  logic                sys_clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic [BUF_SIZE-1:0] data_in = '0;
  logic [CNT_W-1:0]    write_count = '0;
  logic                end_frame = 1'b0;
  logic                miso_inv = 1'b0;
  logic                miso_in;
  logic                sclk_out, ss_out, mosi_out, done_sig, busy;
  logic [BUF_SIZE-1:0] data_out;

  int checks = 0;
  int failures = 0;
  int rises = 0;
  int ss_falls = 0;
  bit mosi_seen[$];
  bit m_hold = 1'b0;
  bit m_mosi = 1'b0;

  always #5 sys_clk = ~sys_clk;

  // Slave model: echoes MOSI back, optionally inverted.
  assign miso_in = mosi_out ^ miso_inv;

  spi_master_engine #(
    .BUF_SIZE(BUF_SIZE),
    .CLK_DIV (CLK_DIV),
    .SS_SETUP(SS_SETUP)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .start      (start),
    .data_in    (data_in),
    .write_count(write_count),
    .end_frame  (end_frame),
    .miso_in    (miso_in),
    .sclk_out   (sclk_out),
    .ss_out     (ss_out),
    .mosi_out   (mosi_out),
    .data_out   (data_out),
    .done_sig   (done_sig),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge sclk_out) begin
    rises++;
    mosi_seen.push_back(mosi_out);
    chk("ss_high_while_sclk", ss_out, 1);
  end

  always @(negedge ss_out) ss_falls++;

  // Reference model: k-th bit on the wire for a transfer of n bits.
  function automatic bit model_bit(input logic [BUF_SIZE-1:0] d, input int n, input int k);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return d[k];
`else
    return d[n-1-k];
`endif
  endfunction

  function automatic int clamp_n(input int wc);
    return (wc > BUF_SIZE) ? BUF_SIZE : wc;
  endfunction

  function automatic int model_lat(input int n, input bit from_hold);
    if (n == 0)    return 1;
    if (from_hold) return 1 + (2 * n + 1) * CLK_DIV;
    return 1 + SS_SETUP + 2 * n * CLK_DIV;
  endfunction

  function automatic logic [BUF_SIZE-1:0] model_word(input logic [BUF_SIZE-1:0] d, input int n,
                                                     input bit inv);
    logic [BUF_SIZE-1:0] mask;
    mask = BUF_SIZE'((1 << n) - 1);
    return (inv ? ~d : d) & mask;
  endfunction

  task automatic run_xfer(input logic [BUF_SIZE-1:0] d, input int wc, input bit ef, input bit inv,
                          input int glitch_at, input string tag,
                          output int lat, output logic [BUF_SIZE-1:0] dout, output int nrise);
    int n, cyc, exp_falls;
    bit busy_ok, stream_ok;
    n = clamp_n(wc);
    exp_falls = (ef && (n > 0 || m_hold)) ? 1 : 0;
    @(negedge sys_clk);
    rises = 0;
    ss_falls = 0;
    mosi_seen.delete();
    data_in = d;
    write_count = CNT_W'(wc);
    end_frame = ef;
    miso_inv = inv;
    start = 1'b1;
    cyc = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge sys_clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        data_in = ~d;
        write_count = '0;
      end
      if (glitch_at > 0 && cyc == glitch_at) begin
        start = 1'b1;
        write_count = CNT_W'(3);
        end_frame = ~ef;
      end
      if (glitch_at > 0 && cyc == glitch_at + 1) start = 1'b0;
      if (n > 0 && !done_sig && !busy) busy_ok = 1'b0;
    end while (!done_sig && cyc < 2000);
    start = 1'b0;
    lat = cyc;
    dout = data_out;
    nrise = rises;
    stream_ok = (mosi_seen.size() == n);
    for (int k = 0; k < n && k < mosi_seen.size(); k++)
      if (mosi_seen[k] != model_bit(d, n, k)) stream_ok = 1'b0;
    if (ef)         m_mosi = 1'b0;
    else if (n > 0) m_mosi = model_bit(d, n, n - 1);
    chk({tag, "_mosi_stream"}, stream_ok, 1);
    chk({tag, "_busy_during"}, busy_ok, 1);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_ss_after"}, ss_out, !ef);
    chk({tag, "_ss_falls"}, ss_falls, exp_falls);
    chk({tag, "_mosi_after"}, mosi_out, m_mosi);
    m_hold = !ef;
  endtask

  typedef struct {
    logic [BUF_SIZE-1:0] d;
    int                  wc;
    bit                  ef;
    bit                  inv;
    logic [BUF_SIZE-1:0] exp_data;
    int                  exp_rises;
    int                  exp_lat;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int lat, nrise, n, wc, falls_before;
    logic [BUF_SIZE-1:0] dout, d, packed_stream;
    bit ef, inv;

    vecs[0] = '{9'h1A5,  9, 1'b1, 1'b0, 9'h1A5, 9, 39};
    vecs[1] = '{9'h1A5,  0, 1'b1, 1'b0, 9'h000, 0, 1};
    vecs[2] = '{9'h0C3, 15, 1'b1, 1'b1, 9'h13C, 9, 39};
    vecs[3] = '{9'h0F3,  4, 1'b1, 1'b0, 9'h003, 4, 19};
    vecs[4] = '{9'h0AA,  1, 1'b1, 1'b1, 9'h001, 1, 7};
    vecs[5] = '{9'h1FF,  9, 1'b1, 1'b1, 9'h000, 9, 39};

    #12;
    chk("rst_sclk", sclk_out, 0);
    chk("rst_ss", ss_out, 0);
    chk("rst_mosi", mosi_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_done", done_sig, 0);
    chk("rst_busy", busy, 0);
    @(negedge sys_clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i].d, vecs[i].wc, vecs[i].ef, vecs[i].inv, 0, $sformatf("vec%0d", i),
               lat, dout, nrise);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_data_out", i), dout, vecs[i].exp_data);
      chk($sformatf("vec%0d_rises", i), nrise, vecs[i].exp_rises);
      if (i == 0) begin
        packed_stream = '0;
        foreach (mosi_seen[k]) packed_stream = {packed_stream[BUF_SIZE-2:0], mosi_seen[k]};
`ifdef SPI_MASTER_LSB_FIRST_EN
        chk("vec0_stream_word", packed_stream, 9'h14B);
`else
        chk("vec0_stream_word", packed_stream, 9'h1A5);
`endif
      end
    end

    // Two transfers with SS held between them.
    run_xfer(9'h0F3, 4, 1'b0, 1'b0, 0, "hold1", lat, dout, nrise);
    chk("hold1_latency", lat, 19);
    chk("hold1_data_out", dout, 9'h003);
    falls_before = ss_falls;
    repeat (3) @(negedge sys_clk);
    chk("hold_gap_done", done_sig, 1);
    chk("hold_gap_ss", ss_out, 1);
    chk("hold_gap_no_fall", ss_falls, falls_before);
    run_xfer(9'h155, 5, 1'b1, 1'b0, 0, "hold2", lat, dout, nrise);
    chk("hold2_latency", lat, 1 + 11 * CLK_DIV);
    chk("hold2_data_out", dout, 9'h015);
    chk("hold2_rises", nrise, 5);

    // Start pulsed mid-transfer must be ignored.
    run_xfer(9'h1A5, 9, 1'b1, 1'b0, 10, "glitch", lat, dout, nrise);
    chk("glitch_latency", lat, 39);
    chk("glitch_data_out", dout, 9'h1A5);
    chk("glitch_rises", nrise, 9);

    // Asynchronous reset at bit 4.
    @(negedge sys_clk);
    rises = 0;
    data_in = 9'h1A5;
    write_count = CNT_W'(9);
    end_frame = 1'b1;
    miso_inv = 1'b0;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    for (int i = 0; i < 500 && rises < 4; i++) @(negedge sys_clk);
    chk("arst_reached_bit4", rises, 4);
    #2 rst = 1'b0;
    #1;
    chk("arst_ss", ss_out, 0);
    chk("arst_sclk", sclk_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done_sig, 0);
    chk("arst_data_out", data_out, 0);
    @(negedge sys_clk);
    rst = 1'b1;
    m_hold = 1'b0;
    m_mosi = 1'b0;
    repeat (4) @(negedge sys_clk);
    chk("arst_no_done_after", done_sig, 0);
    chk("arst_ss_idle", ss_out, 0);
    run_xfer(9'h0B6, 7, 1'b1, 1'b0, 0, "post_rst", lat, dout, nrise);
    chk("post_rst_latency", lat, model_lat(7, 1'b0));
    chk("post_rst_data_out", dout, model_word(9'h0B6, 7, 1'b0));
    chk("post_rst_rises", nrise, 7);

    // Randomized transfers against the model.
    for (int i = 0; i < 24; i++) begin
      int exp_lat;
      d   = BUF_SIZE'($urandom);
      wc  = int'($urandom_range(0, BUF_SIZE + 3));
      ef  = ($urandom_range(0, 3) != 0);
      inv = 1'($urandom_range(0, 1));
      n   = clamp_n(wc);
      exp_lat = model_lat(n, m_hold);
      run_xfer(d, wc, ef, inv, 0, $sformatf("rnd%0d", i), lat, dout, nrise);
      chk($sformatf("rnd%0d_latency", i), lat, exp_lat);
      chk($sformatf("rnd%0d_data_out", i), dout, model_word(d, n, inv));
      chk($sformatf("rnd%0d_rises", i), nrise, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
